// File: rtl/nios_soc_led_pio_if.sv
// rtl/nios_soc_led_pio_if.sv - Avalon-MM slave bus bundle for the LED output PIO
interface nios_soc_led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_soc_led_pio.sv
// rtl/nios_soc_led_pio.sv - LED/buzzer output PIO with set/clear aliases; blink engine under LED_PIO_BLINK_EN
module nios_soc_led_pio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PERIOD_W    = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_soc_led_pio_if.slave     bus,
  output logic [WIDTH-1:0]      out_port
);

  localparam logic [WIDTH-1:0] DATA_RESET = RESET_VALUE[WIDTH-1:0];

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_reg;
  logic [31:0]      rd_next;
  logic             unused_bits;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign wd          = bus.writedata[WIDTH-1:0];
  assign unused_bits = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= DATA_RESET;
    end else if (wr) begin
      case (bus.address)
        3'd0:    data_reg <= wd;
        3'd4:    data_reg <= data_reg | wd;
        3'd5:    data_reg <= data_reg & ~wd;
        default: data_reg <= data_reg;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] blink_cnt;
  logic                phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
    end else if (wr && bus.address == 3'd1) begin
      blink_mask <= wd;
    end
  end

  // A period write restarts the engine and overrides any wrap in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period    <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (wr && bus.address == 3'd2) begin
      period    <= bus.writedata[PERIOD_W-1:0];
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (period == '0) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == period - PERIOD_W'(1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + PERIOD_W'(1);
    end
  end

  assign out_port = data_reg & ~(blink_mask & {WIDTH{phase}});

  always_comb begin
    rd_next = 32'h0;
    case (bus.address)
      3'd0:    rd_next = 32'(data_reg);
      3'd1:    rd_next = 32'(blink_mask);
      3'd2:    rd_next = 32'(period);
      3'd3:    rd_next = {31'h0, phase};
      default: rd_next = 32'h0;
    endcase
  end
`else
  assign out_port = data_reg;

  always_comb begin
    rd_next = 32'h0;
    if (bus.address == 3'd0) rd_next = 32'(data_reg);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'h0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_nios_soc_led_pio.sv
// tb/tb_nios_soc_led_pio.sv - directed self-checking bench for nios_soc_led_pio
module tb_nios_soc_led_pio;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
  int         checks = 0;
  int         errors = 0;

  nios_soc_led_pio_if bus ();

  nios_soc_led_pio #(.WIDTH(8), .RESET_VALUE(32'h5A), .PERIOD_W(24)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the following falling edge sees the result.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    cyc();
    idle();
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    cyc();
    check(tag, bus.readdata, exp);
    idle();
  endtask

  initial begin
    bus.address = 3'd0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out_port), 32'h5A);
    check("rst_rd", bus.readdata, 32'h0);
    reset_n = 1'b1;
    rd("rd_data_rst", 3'd0, 32'h5A);

    wr(3'd0, 32'h0F); check("out_data", 32'(out_port), 32'h0F);
    wr(3'd4, 32'h30); check("out_set", 32'(out_port), 32'h3F);
    wr(3'd5, 32'h03); check("out_clr", 32'(out_port), 32'h3C);
    rd("rd_set", 3'd4, 32'h0);
    rd("rd_clr", 3'd5, 32'h0);
    rd("rd_data", 3'd0, 32'h3C);
    rd("rd_res6", 3'd6, 32'h0);
    rd("rd_res7", 3'd7, 32'h0);
    wr(3'd6, 32'hFF); check("out_res_wr", 32'(out_port), 32'h3C);

    // Read and write DATA together: old value first, new value next cycle.
    bus.address = 3'd0;
    wr(3'd0, 32'h11);
    check("rw_old", bus.readdata, 32'h3C);
    cyc();
    check("rw_new", bus.readdata, 32'h11);

    wr(3'd0, 32'hFFFF_FFA5);
    check("out_trunc", 32'(out_port), 32'hA5);
    rd("rd_trunc", 3'd0, 32'hA5);

`ifdef LED_PIO_BLINK_EN
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h81);
    rd("rd_mask", 3'd1, 32'h81);
    wr(3'd2, 32'h3);
    bus.address = 3'd3;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("blink_out%0d", k), 32'(out_port), ((k / 3) % 2) ? 32'h7E : 32'hFF);
      if (k > 0) check($sformatf("blink_st%0d", k), bus.readdata, 32'(((k - 1) / 3) % 2));
      cyc();
    end
    wr(3'd2, 32'h3);
    repeat (3) cyc();
    check("pre_stop", 32'(out_port), 32'h7E);
    wr(3'd2, 32'h0);
    check("stop_out", 32'(out_port), 32'hFF);
    bus.address = 3'd3;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("stop_hold%0d", k), 32'(out_port), 32'hFF);
      check($sformatf("stop_st%0d", k), bus.readdata, 32'h0);
    end
    wr(3'd2, 32'h3);
    repeat (4) cyc();
    check("pre_rst_blink", 32'(out_port), 32'h7E);
`else
    wr(3'd1, 32'h81);
    wr(3'd2, 32'h3);
    wr(3'd3, 32'h1);
    rd("nb_rd_mask", 3'd1, 32'h0);
    rd("nb_rd_per", 3'd2, 32'h0);
    rd("nb_rd_st", 3'd3, 32'h0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("nb_hold%0d", k), 32'(out_port), 32'hA5);
      cyc();
    end
`endif

    // Asynchronous reset between edges, with readdata nonzero beforehand.
    bus.address = 3'd0;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out_port), 32'h5A);
    check("arst_rd", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("post_rst_data", 3'd0, 32'h5A);
`ifdef LED_PIO_BLINK_EN
    rd("post_rst_per", 3'd2, 32'h0);
    rd("post_rst_st", 3'd3, 32'h0);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'h2);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("restart%0d", k), 32'(out_port), ((k / 2) % 2) ? 32'h50 : 32'h5A);
      cyc();
    end
`else
    check("post_rst_out", 32'(out_port), 32'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_soc_led_pio.md
# nios_soc_led_pio

Avalon-MM output PIO slave for the NIOS SoC alarm clock: the write-side counterpart to the button input port. It holds a CPU-writable output register driving `out_port` (LEDs / buzzer enable), with atomic bit-set/bit-clear aliases and an optional hardware blink engine. The blink engine toggles selected bits at a programmable half-period without CPU involvement. It sits on the system interconnect beside the other PIOs, clocked by the system clock.

## Interface
- `WIDTH`, 8: output port width (1..32).
- `RESET_VALUE`, 0: `out_port` / data register value after reset.
- `PERIOD_W`, 24: width of the blink half-period register and counter (1..32).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data, zero-extended.
- `out_port`  out  WIDTH  driven output pins.

## Operation
- Write strobe `wr = chipselect & ~write_n`. Only `writedata[WIDTH-1:0]` (or `[PERIOD_W-1:0]`) is used.
- Register map:
  - 0 DATA, RW: a write loads `data_reg`.
  - 1 BLINK_MASK, RW: bits that blink.
  - 2 BLINK_PERIOD, RW: half-period in clocks. A write also clears `blink_cnt` and `phase`.
  - 3 STATUS, RO: bit0 = `phase`. Writes are ignored.
  - 4 OUTSET, WO: `data_reg <= data_reg | wd`. Reads return 0.
  - 5 OUTCLEAR, WO: `data_reg <= data_reg & ~wd`. Reads return 0.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- Blink engine:
  - When `period == 0`: `blink_cnt` is held at 0 and `phase` is held at 0.
  - Otherwise, each clock: if `blink_cnt == period-1`, then `blink_cnt <= 0` and `phase` toggles; else `blink_cnt` increments.
  - `period == 1` toggles `phase` every clock.
- Output: `out_port = data_reg & ~(blink_mask & {WIDTH{phase}})`. Masked bits are forced low while `phase = 1`.
- `out_port` is a pure function of registered state, so it is glitch-free.
- A write to BLINK_PERIOD in the same cycle the counter would wrap: the write wins (counter 0, phase 0, no toggle).

## Timing
- Reset values:
  - `data_reg = RESET_VALUE`; `blink_mask = 0`; `period = 0`; `blink_cnt = 0`; `phase = 0`.
  - `readdata = 0`; `out_port = RESET_VALUE`.
- Reset assertion is immediate and asynchronous, including mid-blink. Release takes effect on the first `clk` edge after deassertion.
- Writes are single-cycle with no wait states. The new value appears on `out_port` immediately after the capturing edge.
- `readdata` is updated every clock from `address`, regardless of `chipselect`, giving 1-cycle read latency.
- A read of DATA in the cycle after a write returns the new value.
- Simultaneous read and write to DATA: `readdata` captures the old value.

## Configuration
- `LED_PIO_BLINK_EN` defined: blink engine and registers 1–3 are present as specified above.
- `LED_PIO_BLINK_EN` undefined:
  - No counter, `phase`, mask or period storage.
  - Addresses 1–3 read 0 and ignore writes.
  - `out_port = data_reg`.
  - DATA, OUTSET and OUTCLEAR behave identically to the blink-enabled build.

## Test plan
- Reset with `RESET_VALUE = 0x5A` → `out_port = 0x5A`, `readdata = 0`. Read addr 0 → `0x0000005A` one cycle later.
- Write DATA = `0x0F`; OUTSET `0x30`; OUTCLEAR `0x03` → `out_port` goes `0x0F` → `0x3F` → `0x3C`. Reads of addr 4 and 5 return 0.
- DATA = `0xFF`, MASK = `0x81`, PERIOD = 3 → `out_port` alternates `0xFF` (3 clk) and `0x7E` (3 clk). STATUS bit0 tracks the phase.
- Mid-blink while `phase = 1`, write PERIOD = 0 → next cycle `out_port = 0xFF`, STATUS = 0, and it stays there.
- Assert `reset_n` low mid-blink, asynchronously between edges → all outputs take their reset values at once, and the counter restarts from 0 after release.
- Build without `LED_PIO_BLINK_EN`: write MASK and PERIOD → reads return 0 and `out_port` equals DATA throughout.
